// File: rtl/aes_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_spi_pkg
//  Description : Shared types and constants for the AES block <-> SPI link.
//                The block sequencer and the SPI master both import it.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_spi_pkg;

    // Word width carried by the SPI master DATA_IN / DATA_OUT ports
    localparam int SPI_WORD_W = 16;

    // One AES block
    localparam int AES_BLK_W  = 128;

    // Block sequencer states
    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_SEND   = 3'd1,
        SEQ_WAIT   = 3'd2,
        SEQ_GAP    = 3'd3,
        SEQ_FINISH = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_block_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_block_sequencer
//  Description : Splits a block into WORDS words, pushes each one through the
//                SPI master's data_valid/DONE handshake (word 0 = LSBs first),
//                gathers the returned words into a result block, and aborts
//                the block if DONE does not rise within TIMEOUT_CYC cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_block_sequencer
    import aes_spi_pkg::*;
#(
    parameter int WORDS       = 8,
    parameter int WORD_W      = SPI_WORD_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [WORDS*WORD_W-1:0]   blk_in,
    input  logic                      blk_valid,
    output logic                      blk_ready,
    output logic [WORDS*WORD_W-1:0]   blk_out,
    output logic                      blk_out_valid,
    output logic                      err_timeout,
    output logic [WORD_W-1:0]         spi_data_in,
    output logic                      spi_data_valid,
    input  logic                      spi_done,
    input  logic [WORD_W-1:0]         spi_data_out
);

    localparam int IDX_W = (WORDS > 1)       ? $clog2(WORDS)       : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYC - 1);

    seq_state_t                       state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             done_q, done_d;
    logic [WORDS-1:0][WORD_W-1:0]     tx_q, tx_d;
    logic [WORDS-1:0][WORD_W-1:0]     rx_q, rx_d;
    logic [WORDS-1:0][WORD_W-1:0]     blk_out_q, blk_out_d;
    logic                             blk_out_valid_q, blk_out_valid_d;

    // Only a low-to-high transition of DONE completes a word; a level held
    // high (including one already high out of reset) is not a completion.
    logic                             w_done_rise;
    assign w_done_rise = spi_done & ~done_q;

    assign blk_out       = blk_out_q;
    assign blk_out_valid = blk_out_valid_q;

    // State register and datapath flops; done_q resets high to mask a stuck DONE
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= SEQ_IDLE;
            idx_q           <= '0;
            cnt_q           <= '0;
            done_q          <= 1'b1;
            tx_q            <= '0;
            rx_q            <= '0;
            blk_out_q       <= '0;
            blk_out_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
            done_q          <= done_d;
            tx_q            <= tx_d;
            rx_q            <= rx_d;
            blk_out_q       <= blk_out_d;
            blk_out_valid_q <= blk_out_valid_d;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        cnt_d           = cnt_q;
        done_d          = spi_done;
        tx_d            = tx_q;
        rx_d            = rx_q;
        blk_out_d       = blk_out_q;
        blk_out_valid_d = 1'b0;
        blk_ready       = 1'b0;
        err_timeout     = 1'b0;
        spi_data_in     = '0;
        spi_data_valid  = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    tx_d    = blk_in;
                    rx_d    = '0;
                    idx_d   = '0;
                    state_d = SEQ_SEND;
                end
            end

            SEQ_SEND: begin
                spi_data_in    = tx_q[idx_q];
                spi_data_valid = 1'b1;
                cnt_d          = '0;
                state_d        = SEQ_WAIT;
            end

            SEQ_WAIT: begin
                spi_data_in = tx_q[idx_q];
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A completion arriving on the last allowed cycle still counts
                if (w_done_rise) begin
                    rx_d[idx_q] = spi_data_out;
                    state_d     = SEQ_GAP;
                end else if (cnt_q == LAST_WAIT) begin
                    err_timeout = 1'b1;
                    state_d     = SEQ_IDLE;
                end
            end

            SEQ_GAP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = SEQ_FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = SEQ_SEND;
                end
            end

            SEQ_FINISH: begin
                blk_out_d       = rx_q;
                blk_out_valid_d = 1'b1;
                state_d         = SEQ_IDLE;
            end

            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_block_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_block_sequencer
//  Description : Directed, table-driven bench for spi_block_sequencer with a
//                behavioural SPI responder (loopback or indexed reply, fixed
//                latency, optional stalled word, forced DONE).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_block_sequencer;
    import aes_spi_pkg::*;

    localparam int WORDS       = 8;
    localparam int WORD_W      = SPI_WORD_W;
    localparam int TIMEOUT_CYC = 64;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [AES_BLK_W-1:0]   blk_in = '0;
    logic                   blk_valid = 1'b0;
    logic                   blk_ready;
    logic [AES_BLK_W-1:0]   blk_out;
    logic                   blk_out_valid;
    logic                   err_timeout;
    logic [WORD_W-1:0]      spi_data_in;
    logic                   spi_data_valid;
    logic                   spi_done = 1'b0;
    logic [WORD_W-1:0]      spi_data_out = '0;

    spi_block_sequencer #(
        .WORDS       (WORDS),
        .WORD_W      (WORD_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .blk_in         (blk_in),
        .blk_valid      (blk_valid),
        .blk_ready      (blk_ready),
        .blk_out        (blk_out),
        .blk_out_valid  (blk_out_valid),
        .err_timeout    (err_timeout),
        .spi_data_in    (spi_data_in),
        .spi_data_valid (spi_data_valid),
        .spi_done       (spi_done),
        .spi_data_out   (spi_data_out)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Responder controls / observations
    int           resp_lat = 2;
    bit           resp_idx_mode = 1'b0;
    int           stall_word = -1;
    int           wcount = 0;
    int           valid_cnt = 0;
    int           back2back = 0;
    int           stall_send_cyc = -1;
    bit           force_done = 1'b0;
    bit           man_pulse = 1'b0;
    logic [15:0]  man_data = '0;
    logic [15:0]  sent [0:15];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural SPI master: replies resp_lat cycles after each data_valid
    initial begin : responder
        int          cd;
        bit          drive;
        bit          prev_valid;
        logic [15:0] resp;
        cd = 0; prev_valid = 1'b0; resp = '0;
        forever begin
            @(negedge clock);
            drive = 1'b0;
            if (reset) begin
                cd = 0;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    drive        = 1'b1;
                    spi_data_out = resp;
                end
            end
            if (man_pulse) begin
                drive        = 1'b1;
                spi_data_out = man_data;
                man_pulse    = 1'b0;
            end
            if (spi_data_valid) begin
                if (prev_valid) back2back++;
                if (wcount < 16) sent[wcount] = spi_data_in;
                if (wcount == stall_word) begin
                    stall_send_cyc = cyc;
                end else begin
                    cd   = resp_lat;
                    resp = resp_idx_mode ? (16'hA000 + 16'(wcount)) : spi_data_in;
                end
                wcount++;
                valid_cnt++;
            end
            prev_valid = spi_data_valid;
            spi_done   = drive | force_done;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        check({tag, " blk_ready"},      blk_ready,      1);
        check({tag, " blk_out"},        blk_out,        0);
        check({tag, " blk_out_valid"},  blk_out_valid,  0);
        check({tag, " err_timeout"},    err_timeout,    0);
        check({tag, " spi_data_in"},    spi_data_in,    0);
        check({tag, " spi_data_valid"}, spi_data_valid, 0);
    endtask

    // Waits (bounded) for blk_out_valid; called at posedge+1
    task automatic wait_out_valid(output int n, output bit got, output int ready_bad);
        n = 0; got = 1'b0; ready_bad = 0;
        while (n < 2000) begin
            if (blk_out_valid) begin
                got = 1'b1;
                break;
            end
            if (blk_ready) ready_bad++;
            @(posedge clock); #1;
            n++;
        end
    endtask

    // Sends one block; entered and left at posedge+1
    task automatic run_block(input string name, input logic [127:0] blk, input int lat,
                             input bit idx_mode, input bit hold, input logic [127:0] exp,
                             input int exp_lat, input bit chk_order);
        int          n;
        bit          got;
        int          ready_bad;
        logic [127:0] w;
        resp_lat = lat; resp_idx_mode = idx_mode; stall_word = -1;
        wcount = 0; valid_cnt = 0; back2back = 0;
        check({name, " ready before"}, blk_ready, 1);
        blk_in = blk; blk_valid = 1'b1;
        @(posedge clock); #1;
        if (!hold) blk_valid = 1'b0;
        check({name, " accept ready/valid"}, {blk_ready, spi_data_valid}, 2'b01);
        wait_out_valid(n, got, ready_bad);
        check({name, " completed"}, got, 1);
        check({name, " latency"}, n + 1, exp_lat);
        check({name, " blk_out"}, blk_out, exp);
        check({name, " ready low while busy"}, ready_bad, 0);
        check({name, " valid pulses"}, valid_cnt, 8);
        check({name, " back-to-back valid"}, back2back, 0);
        check({name, " ready at done"}, blk_ready, 1);
        if (chk_order) begin
            w = blk;
            for (int k = 0; k < 8; k++)
                check($sformatf("%s word%0d order", name, k), sent[k], w[16*k +: 16]);
        end
        if (!hold) begin
            @(posedge clock); #1;
            check({name, " single pulse"}, blk_out_valid, 0);
            check({name, " blk_out held"}, blk_out, exp);
        end
    endtask

    typedef struct {
        logic [127:0] blk;
        int           lat;
        bit           idx_mode;
        logic [127:0] exp;
        int           exp_lat;
    } vec_t;

    vec_t vecs [4];

    initial begin : main
        int           n;
        bit           got;
        int           ready_bad;
        int           bad_outv;
        int           err_cyc;
        int           spurious;
        vecs[0] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 3, 1'b0,
                    128'h00112233_44556677_8899AABB_CCDDEEFF, 42};
        vecs[1] = '{128'h0, 1, 1'b1,
                    128'hA007_A006_A005_A004_A003_A002_A001_A000, 26};
        vecs[2] = '{128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 5, 1'b0,
                    128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 58};
        vecs[3] = '{128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0, 2, 1'b1,
                    128'hA007_A006_A005_A004_A003_A002_A001_A000, 34};

        repeat (3) @(posedge clock);
        #1;
        chk_reset_outs("por");
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle ready", blk_ready, 1);

        for (int i = 0; i < 4; i++)
            run_block($sformatf("vec%0d", i), vecs[i].blk, vecs[i].lat, vecs[i].idx_mode,
                      1'b0, vecs[i].exp, vecs[i].exp_lat, (i == 0));

        // Busy: blk_valid held high, one block per IDLE visit
        run_block("busy", vecs[0].blk, 2, 1'b0, 1'b1, vecs[0].exp, 34, 1'b0);
        @(posedge clock); #1;
        check("busy reaccept valid", spi_data_valid, 1);
        check("busy reaccept ready", blk_ready, 0);
        blk_valid = 1'b0;
        wait_out_valid(n, got, ready_bad);
        check("busy second done", got, 1);
        check("busy second blk_out", blk_out, vecs[0].exp);
        check("busy total pulses", valid_cnt, 16);
        @(posedge clock); #1;

        // Timeout on word 3
        resp_lat = 2; resp_idx_mode = 1'b0; stall_word = 3;
        wcount = 0; valid_cnt = 0; stall_send_cyc = -1;
        blk_in = 128'hCAFEF00D_0BADBEEF_13579BDF_2468ACE0; blk_valid = 1'b1;
        @(posedge clock); #1;
        blk_valid = 1'b0;
        n = 0; got = 1'b0; bad_outv = 0; err_cyc = -1;
        while (n < 500) begin
            if (err_timeout) begin
                got = 1'b1; err_cyc = cyc;
                break;
            end
            if (blk_out_valid) bad_outv++;
            @(posedge clock); #1;
            n++;
        end
        check("timeout seen", got, 1);
        check("timeout delay", err_cyc - stall_send_cyc, TIMEOUT_CYC);
        check("timeout words sent", valid_cnt, 4);
        @(posedge clock); #1;
        check("timeout ready after", blk_ready, 1);
        check("timeout single pulse", err_timeout, 0);
        check("timeout blk_out kept", blk_out, vecs[0].exp);
        check("timeout no out_valid", bad_outv + int'(blk_out_valid), 0);

        // Reset during word 4
        resp_lat = 2; resp_idx_mode = 1'b0; stall_word = -1;
        wcount = 0; valid_cnt = 0;
        blk_in = vecs[2].blk; blk_valid = 1'b1;
        @(posedge clock); #1;
        blk_valid = 1'b0;
        n = 0;
        while (n < 500 && valid_cnt < 5) begin
            @(posedge clock); #1;
            n++;
        end
        check("midreset reached word4", valid_cnt, 5);
        reset = 1'b1;
        @(posedge clock); #1;
        chk_reset_outs("midreset");
        reset = 1'b0;
        spurious = 0;
        repeat (80) begin
            @(posedge clock); #1;
            if (blk_out_valid || err_timeout || spi_data_valid) spurious++;
        end
        check("midreset quiet", spurious, 0);
        run_block("after reset", vecs[0].blk, 1, 1'b0, 1'b0, vecs[0].exp, 26, 1'b0);

        // DONE stuck high across reset release
        force_done = 1'b1; reset = 1'b1;
        stall_word = 0; resp_lat = 2; resp_idx_mode = 1'b0;
        wcount = 0; valid_cnt = 0;
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b0;
        blk_in = 128'h11112222_33334444_55556666_77778888; blk_valid = 1'b1;
        @(posedge clock); #1;
        blk_valid = 1'b0;
        check("stuck first send", spi_data_valid, 1);
        repeat (4) begin @(posedge clock); #1; end
        force_done = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        check("stuck no capture", valid_cnt, 1);
        check("stuck still waiting", blk_ready, 0);
        man_data = 16'h5A5A; man_pulse = 1'b1;
        wait_out_valid(n, got, ready_bad);
        check("stuck completed", got, 1);
        check("stuck blk_out", blk_out, 128'h11112222_33334444_55556666_7777_5A5A);
        check("stuck pulses", valid_cnt, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
